// File: rtl/pe_seq_pkg.sv
// pe_seq_pkg: shared state type, default widths and tile timing
// helper for the pe_array loop-nest sequencer.
package pe_seq_pkg;

  localparam int DIM_W_DEF  = 12;
  localparam int ADDR_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    DRAIN,
    WRITE,
    DONE
  } seq_state_t;

  // Cycles between consecutive tile starts.
  function automatic int unsigned tile_period(
    input int unsigned k,
    input int unsigned lat
  );
    return k + 1 + lat;
  endfunction

endpackage

// File: rtl/pe_array_seq_if.sv
// pe_array_seq_if: operand/result bundle between the sequencer
// (master) and the pe_array (slave).
interface pe_array_seq_if #(
  parameter int MAC_NUM = 4,
  parameter int BW_ACT  = 8,
  parameter int BW_WET  = 8
);

  logic                                  PE_mac_enable;
  logic                                  PE_clear_acc;
  logic signed [MAC_NUM-1:0][BW_ACT-1:0] PE_act_in;
  logic signed [BW_WET-1:0]              PE_wet_in;
  logic [7:0]                            PE_res_shift_num;
  logic signed [MAC_NUM-1:0][BW_ACT-1:0] PE_result_out;

  modport master (
    output PE_mac_enable,
    output PE_clear_acc,
    output PE_act_in,
    output PE_wet_in,
    output PE_res_shift_num,
    input  PE_result_out
  );

  modport slave (
    input  PE_mac_enable,
    input  PE_clear_acc,
    input  PE_act_in,
    input  PE_wet_in,
    input  PE_res_shift_num,
    output PE_result_out
  );

endinterface

// File: rtl/pe_seq_addr_gen.sv
// pe_seq_addr_gen: i/j/m loop counters and running SRAM pointers
// (act = j*K+i, wet = i*W+m, oa = j*W+m) built from adds only.
module pe_seq_addr_gen
  import pe_seq_pkg::*;
#(
  parameter int DIM_W  = DIM_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              init,
  input  logic              step,
  input  logic              tile_adv,
  input  logic [DIM_W-1:0]  k,
  input  logic [DIM_W-1:0]  h_tiles,
  input  logic [DIM_W-1:0]  w,
  output logic [ADDR_W-1:0] act_ptr,
  output logic [ADDR_W-1:0] wet_ptr,
  output logic [ADDR_W-1:0] oa_ptr,
  output logic              last_i,
  output logic              last_tile
);

  logic [DIM_W-1:0]  i, j, m;
  logic              last_j;
  logic [ADDR_W-1:0] w_a, m_a;

  assign last_i    = i == k - 1'b1;
  assign last_j    = j == h_tiles - 1'b1;
  assign last_tile = last_j && (m == w - 1'b1);
  assign w_a       = ADDR_W'(w);
  assign m_a       = ADDR_W'(m);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i       <= '0;
      j       <= '0;
      m       <= '0;
      act_ptr <= '0;
      wet_ptr <= '0;
      oa_ptr  <= '0;
    end else if (init) begin
      i       <= '0;
      j       <= '0;
      m       <= '0;
      act_ptr <= '0;
      wet_ptr <= '0;
      oa_ptr  <= '0;
    end else begin
      // i wrap already points the read pointers at the next tile
      if (step) begin
        if (last_i) begin
          i       <= '0;
          act_ptr <= last_j ? '0 : act_ptr + 1'b1;
          wet_ptr <= last_j ? m_a + 1'b1 : m_a;
        end else begin
          i       <= i + 1'b1;
          act_ptr <= act_ptr + 1'b1;
          wet_ptr <= wet_ptr + w_a;
        end
      end
      if (tile_adv) begin
        if (last_j) begin
          j      <= '0;
          m      <= m + 1'b1;
          oa_ptr <= m_a + 1'b1;
        end else begin
          j      <= j + 1'b1;
          oa_ptr <= oa_ptr + w_a;
        end
      end
    end
  end

endmodule

// File: rtl/pe_array_seq.sv
// pe_array_seq: loop-nest sequencer feeding pe_array from SRAMs.
// Optional PE_SEQ_PERF_EN adds a 32-bit busy-cycle counter.
module pe_array_seq
  import pe_seq_pkg::*;
#(
  parameter int MAC_NUM    = 4,
  parameter int BW_ACT     = 8,
  parameter int BW_WET     = 8,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DIM_W      = DIM_W_DEF,
  parameter int PE_RES_LAT = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [DIM_W-1:0]          cfg_k,
  input  logic [DIM_W-1:0]          cfg_h_tiles,
  input  logic [DIM_W-1:0]          cfg_w,
  input  logic [7:0]                cfg_shift,
  output logic                      busy,
  output logic                      done,
`ifdef PE_SEQ_PERF_EN
  output logic [31:0]               perf_cycles,
`endif
  output logic                      act_rd_en,
  output logic [ADDR_W-1:0]         act_rd_addr,
  input  logic [MAC_NUM*BW_ACT-1:0] act_rd_data,
  output logic                      wet_rd_en,
  output logic [ADDR_W-1:0]         wet_rd_addr,
  input  logic [BW_WET-1:0]         wet_rd_data,
  output logic                      oa_wr_en,
  output logic [ADDR_W-1:0]         oa_wr_addr,
  output logic [MAC_NUM*BW_ACT-1:0] oa_wr_data,
  pe_array_seq_if.master            pe
);

  seq_state_t        state, nstate;
  logic [DIM_W-1:0]  k_q, h_q, w_q;
  logic [7:0]        shift_q;
  logic [3:0]        dcnt;
  logic              mac_en, clr, done_q;
  logic              oa_en_q;
  logic [ADDR_W-1:0] oa_addr_q;
  logic [ADDR_W-1:0] act_ptr, wet_ptr, oa_ptr;
  logic              last_i, last_tile;
  logic              accept, zero_cfg, drain_end;

  assign accept    = (state == IDLE) && start;
  assign zero_cfg  = (cfg_k == '0) || (cfg_h_tiles == '0)
                  || (cfg_w == '0);
  assign drain_end = dcnt == 4'(PE_RES_LAT - 1);

  pe_seq_addr_gen #(
    .DIM_W  (DIM_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .init      (accept),
    .step      (state == FEED),
    .tile_adv  (state == WRITE),
    .k         (k_q),
    .h_tiles   (h_q),
    .w         (w_q),
    .act_ptr   (act_ptr),
    .wet_ptr   (wet_ptr),
    .oa_ptr    (oa_ptr),
    .last_i    (last_i),
    .last_tile (last_tile)
  );

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (start) nstate = zero_cfg ? DONE : FEED;
      FEED:    if (last_i) nstate = DRAIN;
      DRAIN:   if (drain_end) nstate = WRITE;
      WRITE:   nstate = last_tile ? DONE : FEED;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      k_q       <= '0;
      h_q       <= '0;
      w_q       <= '0;
      shift_q   <= '0;
      dcnt      <= '0;
      mac_en    <= 1'b0;
      clr       <= 1'b1;
      done_q    <= 1'b0;
      oa_en_q   <= 1'b0;
      oa_addr_q <= '0;
    end else begin
      state <= nstate;
      if (accept) begin
        k_q     <= cfg_k;
        h_q     <= cfg_h_tiles;
        w_q     <= cfg_w;
        shift_q <= cfg_shift;
      end
      dcnt    <= (state == DRAIN) ? dcnt + 1'b1 : '0;
      // read data lands one cycle after FEED, so operands trail it
      mac_en  <= state == FEED;
      clr     <= state != FEED;
      done_q  <= state == DONE;
      oa_en_q <= state == WRITE;
      if (state == WRITE) oa_addr_q <= oa_ptr;
    end
  end

  assign busy        = state != IDLE;
  assign done        = done_q;
  assign act_rd_en   = state == FEED;
  assign wet_rd_en   = state == FEED;
  assign act_rd_addr = act_ptr;
  assign wet_rd_addr = wet_ptr;
  assign oa_wr_en    = oa_en_q;
  assign oa_wr_addr  = oa_addr_q;
  assign oa_wr_data  = oa_en_q ? pe.PE_result_out : '0;

  assign pe.PE_mac_enable    = mac_en;
  assign pe.PE_clear_acc     = clr;
  assign pe.PE_act_in        = mac_en ? act_rd_data : '0;
  assign pe.PE_wet_in        = mac_en ? wet_rd_data : '0;
  assign pe.PE_res_shift_num = shift_q;

`ifdef PE_SEQ_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    perf_q <= '0;
    else if (accept) perf_q <= '0;
    else if (busy)   perf_q <= perf_q + 1'b1;
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_pe_array_seq.sv
// tb_pe_array_seq: SRAM + behavioural PE models around pe_array_seq,
// with a queue scoreboard checked by an independent output monitor.
module tb_pe_array_seq;
  import pe_seq_pkg::*;

  localparam int MAC_NUM = 4;
  localparam int BW_ACT  = 8;
  localparam int BW_WET  = 8;
  localparam int ADDR_W  = 16;
  localparam int DIM_W   = 12;
  localparam int LAT     = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [DIM_W-1:0] cfg_k = '0;
  logic [DIM_W-1:0] cfg_h_tiles = '0;
  logic [DIM_W-1:0] cfg_w = '0;
  logic [7:0] cfg_shift = '0;
  logic busy, done;
`ifdef PE_SEQ_PERF_EN
  logic [31:0] perf_cycles;
`endif
  logic act_rd_en, wet_rd_en, oa_wr_en;
  logic [ADDR_W-1:0] act_rd_addr, wet_rd_addr, oa_wr_addr;
  logic [MAC_NUM*BW_ACT-1:0] act_rd_data = '0;
  logic [BW_WET-1:0] wet_rd_data = '0;
  logic [MAC_NUM*BW_ACT-1:0] oa_wr_data;

  always #5 clk = ~clk;

  pe_array_seq_if #(
    .MAC_NUM(MAC_NUM), .BW_ACT(BW_ACT), .BW_WET(BW_WET)
  ) pe ();

  pe_array_seq #(
    .MAC_NUM(MAC_NUM), .BW_ACT(BW_ACT), .BW_WET(BW_WET),
    .ADDR_W(ADDR_W), .DIM_W(DIM_W), .PE_RES_LAT(LAT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .cfg_k(cfg_k),
    .cfg_h_tiles(cfg_h_tiles),
    .cfg_w(cfg_w),
    .cfg_shift(cfg_shift),
    .busy(busy),
    .done(done),
`ifdef PE_SEQ_PERF_EN
    .perf_cycles(perf_cycles),
`endif
    .act_rd_en(act_rd_en),
    .act_rd_addr(act_rd_addr),
    .act_rd_data(act_rd_data),
    .wet_rd_en(wet_rd_en),
    .wet_rd_addr(wet_rd_addr),
    .wet_rd_data(wet_rd_data),
    .oa_wr_en(oa_wr_en),
    .oa_wr_addr(oa_wr_addr),
    .oa_wr_data(oa_wr_data),
    .pe(pe)
  );

  // SRAMs: data valid the cycle after the read enable
  logic [31:0] act_mem [256];
  logic [7:0]  wet_mem [256];

  always @(posedge clk) begin
    if (act_rd_en) act_rd_data <= act_mem[act_rd_addr[7:0]];
    if (wet_rd_en) wet_rd_data <= wet_mem[wet_rd_addr[7:0]];
  end

  // PE model: result appears LAT cycles after clear rises
  function automatic logic signed [15:0] mul8(
    input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] xa, xb;
    xa = 16'(signed'(a));
    xb = 16'(signed'(b));
    return xa * xb;
  endfunction

  logic signed [15:0] acc [MAC_NUM];
  logic [MAC_NUM-1:0][BW_ACT-1:0] st1, st2;
  logic clr_d;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < MAC_NUM; n++) acc[n] <= '0;
      st1 <= '0;
      st2 <= '0;
      clr_d <= 1'b1;
    end else begin
      clr_d <= pe.PE_clear_acc;
      st2 <= st1;
      for (int n = 0; n < MAC_NUM; n++) begin
        if (pe.PE_clear_acc && !clr_d)
          st1[n] <= BW_ACT'(acc[n] >>> pe.PE_res_shift_num);
        if (pe.PE_clear_acc) acc[n] <= '0;
        else if (pe.PE_mac_enable)
          acc[n] <= acc[n] + mul8(pe.PE_act_in[n], pe.PE_wet_in);
      end
    end
  end

  assign pe.PE_result_out = st2;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  wr_t got_e;
  int mrun = 0, crun = 0, mism = 0, en_cnt = 0;
  bit carm = 0, clr_prev = 1;

  // Monitor: scoreboard pops plus per-tile enable/clear shape
  always @(negedge clk) begin
    if (!reset_n) begin
      mrun = 0;
      crun = 0;
      carm = 0;
      clr_prev = 1;
    end else begin
      if (act_rd_en || wet_rd_en || oa_wr_en) en_cnt++;
      if (busy && (pe.PE_clear_acc == pe.PE_mac_enable)) mism++;
      if (oa_wr_en) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL oa_unexpected: addr %0h data %0h, none expected",
                   oa_wr_addr, oa_wr_data);
        end else begin
          got_e = sb.pop_front();
          check("oa_addr", 64'(oa_wr_addr), 64'(got_e.addr));
          check("oa_data", 64'(oa_wr_data), 64'(got_e.data));
        end
      end
      if (pe.PE_mac_enable) mrun++;
      else if (mrun != 0) begin
        check("mac_run", 64'(mrun), 64'd8);
        mrun = 0;
      end
      if (!busy) carm = 0;
      else if (pe.PE_clear_acc && !clr_prev) begin
        carm = 1;
        crun = 1;
      end else if (pe.PE_clear_acc && carm) crun++;
      else if (!pe.PE_clear_acc && carm) begin
        check("clr_run", 64'(crun), 64'd3);
        carm = 0;
      end
      clr_prev = pe.PE_clear_acc;
    end
  end

  task automatic check_reset();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rd_en", 64'({act_rd_en, wet_rd_en}), 64'd0);
    check("rst_wr_en", 64'(oa_wr_en), 64'd0);
    check("rst_act_addr", 64'(act_rd_addr), 64'd0);
    check("rst_wet_addr", 64'(wet_rd_addr), 64'd0);
    check("rst_oa_addr", 64'(oa_wr_addr), 64'd0);
    check("rst_oa_data", 64'(oa_wr_data), 64'd0);
    check("rst_mac", 64'(pe.PE_mac_enable), 64'd0);
    check("rst_clr", 64'(pe.PE_clear_acc), 64'd1);
    check("rst_act_in", 64'(pe.PE_act_in), 64'd0);
    check("rst_wet_in", 64'(pe.PE_wet_in), 64'd0);
    check("rst_shift", 64'(pe.PE_res_shift_num), 64'd0);
  endtask

  // mode 0: all ones; mode 1: act[r][c]=r+c, identity weights
  task automatic load_mem(input int mode);
    for (int a = 0; a < 256; a++) begin
      act_mem[a] = '0;
      wet_mem[a] = '0;
    end
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 8; i++)
        for (int n = 0; n < 4; n++)
          act_mem[j*8+i][n*8+:8] = mode != 0 ? 8'(j*4+n+i) : 8'd1;
    for (int i = 0; i < 8; i++)
      for (int m = 0; m < 8; m++)
        if (mode != 0) wet_mem[i*8+m] = (i == m) ? 8'd1 : 8'd0;
        else wet_mem[i*8+m] = 8'd1;
  endtask

  task automatic push_exp(input int mode);
    wr_t e;
    for (int m = 0; m < 8; m++)
      for (int j = 0; j < 2; j++) begin
        e.addr = 16'(j*8+m);
        for (int n = 0; n < 4; n++)
          e.data[n*8+:8] = mode != 0 ? 8'(j*4+n+m) : 8'd8;
        sb.push_back(e);
      end
  endtask

  task automatic run_job(input int k, input int h, input int w,
                         input bit extra, input int exp_lat,
                         input int abort_at);
    int lat;
    bit aborted;
    lat = -1;
    aborted = 0;
    mism = 0;
    @(negedge clk);
    cfg_k = DIM_W'(k);
    cfg_h_tiles = DIM_W'(h);
    cfg_w = DIM_W'(w);
    cfg_shift = 8'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // config must already be latched
    cfg_k = 12'd3;
    cfg_h_tiles = 12'd5;
    cfg_w = 12'd7;
    cfg_shift = 8'd1;
    check("busy_on", 64'(busy), 64'd1);
    for (int t = 0; t < 600; t++) begin
      if (extra) begin
        if (t == 50 || t == 176) start = 1'b1;
        if (t == 52 || t == 177) start = 1'b0;
      end
      if (abort_at > 0 && t == abort_at) begin
        #2 reset_n = 1'b0;
        #1 check_reset();
        sb.delete();
        aborted = 1;
        break;
      end
      if (done) begin
        lat = t;
        break;
      end
      @(negedge clk);
    end
    if (aborted) begin
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
    end else begin
      check("done_lat", 64'(lat), 64'(exp_lat));
      check("busy_off", 64'(busy), 64'd0);
`ifdef PE_SEQ_PERF_EN
      check("perf_cycles", 64'(perf_cycles), 64'(exp_lat));
`endif
      @(negedge clk);
      check("done_pulse", 64'(done), 64'd0);
      repeat (3) @(negedge clk);
      check("sb_empty", 64'(sb.size()), 64'd0);
      check("clr_vs_mac", 64'(mism), 64'd0);
    end
  endtask

  initial begin
    int full_lat;
    full_lat = 16 * int'(tile_period(8, LAT)) + 1;
    repeat (2) @(negedge clk);
    check_reset();
    @(negedge clk);
    reset_n = 1'b1;

    load_mem(0);
    push_exp(0);
    run_job(8, 2, 8, 0, full_lat, 0);

    load_mem(1);
    push_exp(1);
    run_job(8, 2, 8, 0, full_lat, 0);

    en_cnt = 0;
    run_job(8, 2, 0, 0, 1, 0);
    check("zero_no_access", 64'(en_cnt), 64'd0);

    load_mem(0);
    push_exp(0);
    run_job(8, 2, 8, 0, full_lat, 38);

    load_mem(1);
    push_exp(1);
    run_job(8, 2, 8, 0, full_lat, 0);

    load_mem(0);
    push_exp(0);
    run_job(8, 2, 8, 1, full_lat, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_chk++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
